packet_header_parser: RTL and testbench
=======================================

PACKET_HEADER_PARSER -- requirements
Module: packet_header_parser

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating statistics counters.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_data  input  8  ingress frame byte, IPv4 header first.
REQ-005 SHALL have port s_valid  input  1  s_data valid.
REQ-006 SHALL have port s_ready  output  1  parser accepts byte; transfer when s_valid && s_ready.
REQ-007 SHALL have port s_last  input  1  final byte of frame.
REQ-008 SHALL have port m_pkt  output  packet_s  extracted 5-tuple for the rule classifier.
REQ-009 SHALL have port m_valid  output  1  m_pkt valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts m_pkt.
REQ-011 SHALL have port pkt_count  output  CNT_W  tuples emitted, saturating.
REQ-012 SHALL have port drop_count  output  CNT_W  frames dropped, saturating.

Function
REQ-013 SHALL count accepted bytes per frame in a 6-bit index, reset to 0 after each s_last transfer.
REQ-014 SHALL take byte 0 as version[7:4]/IHL[3:0]; version!=4 or IHL<5 marks the frame bad.
REQ-015 SHALL capture byte 9 as protocol, bytes 12-15 as src.ip, bytes 16-19 as dst.ip, MSB first.
REQ-016 SHALL, for protocol 6 or 17, capture L4 bytes IHL*4+0..1 as src.port and IHL*4+2..3 as dst.port, MSB first.
REQ-017 SHALL, for any other protocol, set both ports to 0 and complete the header at byte IHL*4-1.
REQ-018 SHALL implement states HDR (capturing), EMIT (header complete, output slot busy), DRAIN (discarding rest of frame).
REQ-019 SHALL, on the header-completing byte, load m_pkt if slot free (m_valid==0 or m_ready==1 that cycle); m_valid asserts the next cycle.
REQ-020 SHALL, if slot not free, enter EMIT with s_ready=0 until slot frees, then load and leave EMIT.
REQ-021 SHALL go to HDR if the completing byte carried s_last, else DRAIN; in EMIT the same decision applies upon leaving.
REQ-022 SHALL hold s_ready=1 in HDR and DRAIN; DRAIN discards bytes until s_last is accepted, then HDR.
REQ-023 SHALL, on s_last before header completion (truncation), emit nothing, increment drop_count, return to HDR.
REQ-024 SHALL, for a bad frame (REQ-014), emit nothing, increment drop_count once, drain to s_last.
REQ-025 SHALL hold m_pkt and m_valid stable while m_valid && !m_ready; m_valid clears after transfer unless reloaded same cycle.
REQ-026 SHALL increment pkt_count on each m_pkt load; counters saturate at all-ones.
REQ-027 SHALL support back-to-back frames with zero idle cycles when m_ready stays 1.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set state HDR, index 0, m_valid 0, m_pkt all-zero, counters 0; s_ready reads 1 after release.
REQ-029 SHALL discard any partial frame on mid-frame reset; next byte after release is treated as byte 0.

Structure
REQ-030 SHALL place PROTO_TCP=8'd6, PROTO_UDP=8'd17, IPV4_MIN_IHL=4'd5 and the parser state enum in network_pkg with packet_s.
REQ-031 SHALL instantiate one sub-module, packet_slot: single-entry packet_s holding register with valid/ready.

Verification
REQ-032 SHALL test TCP frame, IHL=5, src 10.0.0.1:1234, dst 10.0.0.2:80, 40 bytes, m_ready=1 -> one m_pkt {0x0A000001,0x04D2,0x0A000002,0x0050,0x06}, m_valid one cycle after byte 23, pkt_count=1.
REQ-033 SHALL test ICMP (proto 1) frame, IHL=6, 28 bytes -> m_pkt ports 0, protocol 0x01, loaded on byte 23.
REQ-034 SHALL test byte0=0x65 (version 6) 40-byte frame -> no m_valid, drop_count=1, next valid frame parsed normally.
REQ-035 SHALL test UDP frame with s_last on byte 21 -> no output, drop_count=1, state HDR.
REQ-036 SHALL test two back-to-back UDP frames with m_ready=0 until 10 cycles after second header completes -> s_ready low in EMIT, both tuples delivered in order, no byte lost.
REQ-037 SHALL test rst_n low at byte 14 of a frame -> m_valid 0, counters 0; fresh frame after release parsed correctly.

Source files
------------

// File: rtl/network_pkg.sv
// Shared types and constants for the IPv4 header parser and its output slot.
package network_pkg;

    localparam logic [7:0] PROTO_TCP    = 8'd6;
    localparam logic [7:0] PROTO_UDP    = 8'd17;
    localparam logic [3:0] IPV4_MIN_IHL = 4'd5;
    localparam logic [3:0] IPV4_VERSION = 4'd4;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DRAIN = 2'd2
    } parser_state_e;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [15:0] src_port;
        logic [31:0] dst_ip;
        logic [15:0] dst_port;
        logic [7:0]  protocol;
    } packet_s;

    // TCP and UDP both carry 16-bit source/destination ports first in the L4 header
    function automatic logic is_l4(input logic [7:0] proto);
        return (proto == PROTO_TCP) || (proto == PROTO_UDP);
    endfunction

endpackage

// File: rtl/packet_slot.sv
// Single-entry holding register for an extracted 5-tuple with valid/ready output.
module packet_slot
    import network_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load_i,
    input  packet_s data_i,
    input  logic    ready_i,
    output logic    valid_o,
    output packet_s data_o
);

    logic    valid_q;
    packet_s data_q;

    // A load in the same cycle as a transfer keeps the slot occupied with the new tuple
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/packet_header_parser.sv
// Streams IPv4 frames byte by byte, extracts the 5-tuple and hands it to a one-entry slot.
module packet_header_parser
    import network_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output packet_s          m_pkt,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned IDX_W = 6;

    parser_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       ihl_q, ihl_d;
    logic             last_q, last_d;
    packet_s          hdr_q, hdr_d;
    logic             s_ready_q;
    logic [CNT_W-1:0] pkt_count_q, drop_count_q;

    logic             accept_c, slot_free_c, load_c, drop_c, done_c, bad_c;
    logic [IDX_W-1:0] l4_base_c, l4_off_c;

    assign accept_c    = s_valid && s_ready_q;
    assign slot_free_c = !m_valid || m_ready;
    assign l4_base_c   = {ihl_q, 2'b00};
    assign l4_off_c    = idx_q - l4_base_c;
    assign bad_c       = (idx_q == '0) &&
                         ((s_data[7:4] != IPV4_VERSION) || (s_data[3:0] < IPV4_MIN_IHL));
    // Header ends at the last L4 port byte, or at the last IP header byte when there are no ports
    assign done_c      = (idx_q != '0) &&
                         (is_l4(hdr_q.protocol) ? (idx_q == l4_base_c + IDX_W'(3))
                                                : (idx_q == l4_base_c - IDX_W'(1)));

    // Field capture; hdr_d already includes the byte being accepted this cycle
    always_comb begin
        hdr_d = hdr_q;
        ihl_d = ihl_q;
        if (accept_c && (state_q == ST_HDR)) begin
            if (idx_q == '0) begin
                hdr_d = '0;
                ihl_d = s_data[3:0];
            end else if (idx_q == IDX_W'(9)) begin
                hdr_d.protocol = s_data;
            end else if ((idx_q >= IDX_W'(12)) && (idx_q <= IDX_W'(15))) begin
                hdr_d.src_ip = {hdr_q.src_ip[23:0], s_data};
            end else if ((idx_q >= IDX_W'(16)) && (idx_q <= IDX_W'(19))) begin
                hdr_d.dst_ip = {hdr_q.dst_ip[23:0], s_data};
            end else if (is_l4(hdr_q.protocol) && (idx_q >= l4_base_c)) begin
                if (l4_off_c < IDX_W'(2)) begin
                    hdr_d.src_port = {hdr_q.src_port[7:0], s_data};
                end else if (l4_off_c < IDX_W'(4)) begin
                    hdr_d.dst_port = {hdr_q.dst_port[7:0], s_data};
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        load_c  = 1'b0;
        drop_c  = 1'b0;
        if (accept_c) begin
            idx_d = s_last ? '0 : idx_q + IDX_W'(1);
        end
        case (state_q)
            ST_HDR: begin
                if (accept_c) begin
                    if (bad_c) begin
                        drop_c = 1'b1;
                        if (!s_last) state_d = ST_DRAIN;
                    end else if (done_c) begin
                        if (slot_free_c) begin
                            load_c  = 1'b1;
                            state_d = s_last ? ST_HDR : ST_DRAIN;
                        end else begin
                            state_d = ST_EMIT;
                            last_d  = s_last;
                        end
                    end else if (s_last) begin
                        drop_c = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (slot_free_c) begin
                    load_c  = 1'b1;
                    state_d = last_q ? ST_HDR : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept_c && s_last) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            idx_q        <= '0;
            ihl_q        <= '0;
            last_q       <= 1'b0;
            hdr_q        <= '0;
            s_ready_q    <= 1'b1;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ihl_q     <= ihl_d;
            last_q    <= last_d;
            hdr_q     <= hdr_d;
            s_ready_q <= (state_d != ST_EMIT);
            if (load_c && (pkt_count_q != '1)) pkt_count_q <= pkt_count_q + CNT_W'(1);
            if (drop_c && (drop_count_q != '1)) drop_count_q <= drop_count_q + CNT_W'(1);
        end
    end

    packet_slot u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_c),
        .data_i  (hdr_d),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .data_o  (m_pkt)
    );

    assign s_ready    = s_ready_q;
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_packet_header_parser.sv
// Self-checking bench for packet_header_parser: directed scenarios plus randomized frames.
module tb_packet_header_parser;
    import network_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    packet_s          m_pkt;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] drop_count;

    int checks = 0;
    int passed = 0;

    logic [7:0] fb [0:127];
    int         flen;
    packet_s    rcv_q[$];
    packet_s    exp_q[$];
    int         acc_cnt = 0;
    int         exp_pkt = 0;
    int         exp_drop = 0;
    bit         rnd_done;

    always #5 clk = ~clk;

    packet_header_parser #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_last     (s_last),
        .m_pkt      (m_pkt),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    // Handshake monitor: record transfers that will happen on the coming rising edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) rcv_q.push_back(m_pkt);
        if (rst_n === 1'b1 && s_valid === 1'b1 && s_ready === 1'b1) acc_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input bit gaps);
        if (gaps) begin
            while ($urandom_range(3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        checks++;
        $display("FAIL send_byte_timeout: s_ready=%b for 300 cycles, required 1", s_ready);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < flen; i++) send_byte(fb[i], (i == flen - 1), gaps);
    endtask

    task automatic build_frame(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                               input logic [31:0] sip, input logic [31:0] dip,
                               input logic [15:0] sp, input logic [15:0] dp, input int len);
        int base;
        for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
        fb[0] = {ver, ihl};
        fb[9] = proto;
        for (int k = 0; k < 4; k++) begin
            fb[12 + k] = sip[31 - 8*k -: 8];
            fb[16 + k] = dip[31 - 8*k -: 8];
        end
        if (ihl >= 4'd5) begin
            base = int'(ihl) * 4;
            fb[base]     = sp[15:8];
            fb[base + 1] = sp[7:0];
            fb[base + 2] = dp[15:8];
            fb[base + 3] = dp[7:0];
        end
        flen = len;
    endtask

    // Reference: decide from the frame bytes alone whether a tuple comes out and what it is
    task automatic model_frame(output bit good, output packet_s t);
        int ver, ihl, need;
        bit l4;
        ver  = int'(fb[0] >> 4);
        ihl  = int'(fb[0] & 8'h0F);
        l4   = (fb[9] == 8'd6) || (fb[9] == 8'd17);
        need = ihl * 4 + (l4 ? 4 : 0);
        good = (ver == 4) && (ihl >= 5) && (flen >= need);
        t = '0;
        t.src_ip   = {fb[12], fb[13], fb[14], fb[15]};
        t.dst_ip   = {fb[16], fb[17], fb[18], fb[19]};
        t.protocol = fb[9];
        if (l4 && ihl >= 5) begin
            t.src_port = {fb[ihl*4],     fb[ihl*4 + 1]};
            t.dst_port = {fb[ihl*4 + 2], fb[ihl*4 + 3]};
        end
    endtask

    task automatic expect_frame(output packet_s t);
        bit good;
        model_frame(good, t);
        if (good) begin
            exp_q.push_back(t);
            exp_pkt++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else passed++;
        checks++; if (m_pkt !== '0) $display("FAIL reset_m_pkt: got %h want 0", m_pkt); else passed++;
        checks++; if (pkt_count !== '0 || drop_count !== '0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0", pkt_count, drop_count); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else passed++;
        exp_pkt = 0; exp_drop = 0;
    endtask

    task automatic test_tcp();
        packet_s want;
        want = '{src_ip: 32'h0A000001, src_port: 16'h04D2, dst_ip: 32'h0A000002,
                 dst_port: 16'h0050, protocol: 8'h06};
        rcv_q.delete(); m_ready = 1'b1;
        build_frame(4'd4, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 40);
        exp_pkt++;
        for (int i = 0; i < 23; i++) send_byte(fb[i], 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b0) $display("FAIL tcp_early_valid: got %b want 0", m_valid); else passed++;
        send_byte(fb[23], 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b1) $display("FAIL tcp_valid_after_23: got %b want 1", m_valid); else passed++;
        checks++; if (m_pkt !== want) $display("FAIL tcp_tuple: got %h want %h", m_pkt, want); else passed++;
        for (int i = 24; i < 40; i++) send_byte(fb[i], (i == 39), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pkt_count !== CNT_W'(exp_pkt)) $display("FAIL tcp_pkt_count: got %0d want %0d", pkt_count, exp_pkt); else passed++;
        checks++; if (rcv_q.size() != 1) $display("FAIL tcp_tuple_count: got %0d want 1", rcv_q.size()); else passed++;
    endtask

    task automatic test_icmp();
        packet_s want;
        want = '{src_ip: 32'hC0A80105, src_port: 16'h0000, dst_ip: 32'hC0A801FE,
                 dst_port: 16'h0000, protocol: 8'h01};
        m_ready = 1'b1;
        build_frame(4'd4, 4'd6, 8'd1, 32'hC0A80105, 32'hC0A801FE, 16'($urandom), 16'($urandom), 28);
        exp_pkt++;
        for (int i = 0; i < 23; i++) send_byte(fb[i], 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b0) $display("FAIL icmp_early_valid: got %b want 0", m_valid); else passed++;
        send_byte(fb[23], 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_pkt !== want)
            $display("FAIL icmp_tuple: got valid=%b pkt=%h want 1 %h", m_valid, m_pkt, want); else passed++;
        for (int i = 24; i < 28; i++) send_byte(fb[i], (i == 27), 1'b0);
        @(posedge clk); #1;
        checks++; if (pkt_count !== CNT_W'(exp_pkt)) $display("FAIL icmp_pkt_count: got %0d want %0d", pkt_count, exp_pkt); else passed++;
    endtask

    task automatic test_bad_version();
        packet_s t;
        rcv_q.delete(); m_ready = 1'b1;
        build_frame(4'd6, 4'd5, 8'd6, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 40);
        checks++; if (fb[0] !== 8'h65) $display("FAIL bad_byte0: got %h want 65", fb[0]); else passed++;
        expect_frame(t);
        send_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rcv_q.size() != 0) $display("FAIL bad_no_output: got %0d tuples want 0", rcv_q.size()); else passed++;
        checks++; if (drop_count !== CNT_W'(exp_drop)) $display("FAIL bad_drop_count: got %0d want %0d", drop_count, exp_drop); else passed++;
        build_frame(4'd4, 4'd5, 8'd17, 32'($urandom), 32'($urandom), 16'($urandom), 16'($urandom), 32);
        expect_frame(t);
        send_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rcv_q.size() != 1 || rcv_q[0] !== t)
            $display("FAIL bad_next_frame: got %0d tuples first=%h want 1 %h", rcv_q.size(), rcv_q[0], t); else passed++;
    endtask

    task automatic test_truncated();
        packet_s t;
        rcv_q.delete(); m_ready = 1'b1;
        build_frame(4'd4, 4'd5, 8'd17, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'd53, 16'd53, 22);
        expect_frame(t);
        send_frame(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rcv_q.size() != 0) $display("FAIL trunc_no_output: got %0d tuples want 0", rcv_q.size()); else passed++;
        checks++; if (drop_count !== CNT_W'(exp_drop)) $display("FAIL trunc_drop_count: got %0d want %0d", drop_count, exp_drop); else passed++;
        checks++; if (s_ready !== 1'b1) $display("FAIL trunc_s_ready: got %b want 1", s_ready); else passed++;
        build_frame(4'd4, 4'd5, 8'd6, 32'($urandom), 32'($urandom), 16'($urandom), 16'($urandom), 24);
        expect_frame(t);
        send_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rcv_q.size() != 1 || rcv_q[0] !== t)
            $display("FAIL trunc_next_frame: got %0d tuples first=%h want 1 %h", rcv_q.size(), rcv_q[0], t); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        bit         lasts[$];
        packet_s    ta, tb;
        bit         seen;
        rcv_q.delete(); m_ready = 1'b0;
        build_frame(4'd4, 4'd5, 8'd17, 32'hAC100001, 32'hAC100002, 16'd1111, 16'd2222, 30);
        expect_frame(ta);
        for (int i = 0; i < flen; i++) begin bytes.push_back(fb[i]); lasts.push_back(i == flen - 1); end
        build_frame(4'd4, 4'd5, 8'd17, 32'hAC100003, 32'hAC100004, 16'd3333, 16'd4444, 30);
        expect_frame(tb);
        for (int i = 0; i < flen; i++) begin bytes.push_back(fb[i]); lasts.push_back(i == flen - 1); end
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < bytes.size(); i++) send_byte(bytes[i], lasts[i], 1'b0);
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (!s_ready) begin seen = 1'b1; break; end
                end
                checks++; if (!seen) $display("FAIL b2b_stall: s_ready never dropped, want 0 in EMIT"); else passed++;
                repeat (10) @(negedge clk);
                checks++; if (s_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b want 0", s_ready); else passed++;
                checks++; if (m_valid !== 1'b1 || m_pkt !== ta)
                    $display("FAIL b2b_hold_pkt: got valid=%b pkt=%h want 1 %h", m_valid, m_pkt, ta); else passed++;
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rcv_q.size() != 2) $display("FAIL b2b_count: got %0d tuples want 2", rcv_q.size()); else passed++;
        checks++; if (rcv_q.size() < 1 || rcv_q[0] !== ta) $display("FAIL b2b_first: got %h want %h", rcv_q[0], ta); else passed++;
        checks++; if (rcv_q.size() < 2 || rcv_q[1] !== tb) $display("FAIL b2b_second: got %h want %h", rcv_q[1], tb); else passed++;
        checks++; if (acc_cnt != 60) $display("FAIL b2b_bytes: got %0d accepted want 60", acc_cnt); else passed++;
        checks++; if (pkt_count !== CNT_W'(exp_pkt)) $display("FAIL b2b_pkt_count: got %0d want %0d", pkt_count, exp_pkt); else passed++;
    endtask

    task automatic test_mid_reset();
        packet_s t;
        m_ready = 1'b1;
        build_frame(4'd4, 4'd5, 8'd6, 32'h0A000009, 32'h0A00000A, 16'd7, 16'd8, 40);
        for (int i = 0; i < 14; i++) send_byte(fb[i], 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) $display("FAIL mrst_m_valid: got %b want 0", m_valid); else passed++;
        checks++; if (pkt_count !== '0 || drop_count !== '0)
            $display("FAIL mrst_counters: got %0d/%0d want 0/0", pkt_count, drop_count); else passed++;
        exp_pkt = 0; exp_drop = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (s_ready !== 1'b1) $display("FAIL mrst_s_ready: got %b want 1", s_ready); else passed++;
        rcv_q.delete(); exp_q.delete();
        build_frame(4'd4, 4'd5, 8'd6, 32'($urandom), 32'($urandom), 16'($urandom), 16'($urandom), 26);
        expect_frame(t);
        send_frame(1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rcv_q.size() != 1 || rcv_q[0] !== t)
            $display("FAIL mrst_fresh_frame: got %0d tuples first=%h want 1 %h", rcv_q.size(), rcv_q[0], t); else passed++;
        checks++; if (pkt_count !== CNT_W'(1)) $display("FAIL mrst_pkt_count: got %0d want 1", pkt_count); else passed++;
    endtask

    task automatic test_random();
        packet_s    t;
        logic [3:0] ver, ihl;
        logic [7:0] proto;
        int         r, need, len;
        rcv_q.delete(); exp_q.delete();
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    r     = int'($urandom_range(9));
                    proto = (r < 4) ? 8'd6 : (r < 7) ? 8'd17 : (r < 8) ? 8'd1 : 8'($urandom);
                    ver   = ($urandom_range(15) == 0) ? 4'd6 : 4'd4;
                    r     = int'($urandom_range(9));
                    ihl   = (r == 0) ? 4'($urandom_range(4)) : (r == 1) ? 4'd15 : 4'($urandom_range(8, 5));
                    need  = (ihl < 4'd5) ? 20 : int'(ihl) * 4 + (((proto == 8'd6) || (proto == 8'd17)) ? 4 : 0);
                    len   = ($urandom_range(3) == 0) ? int'($urandom_range(need, 1)) : int'($urandom_range(need + 20, need));
                    build_frame(ver, ihl, proto, 32'($urandom), 32'($urandom), 16'($urandom), 16'($urandom), len);
                    expect_frame(t);
                    send_frame(1'b1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    m_ready = ($urandom_range(2) != 0);
                end
            end
        join
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (rcv_q.size() != exp_q.size())
            $display("FAIL rnd_count: got %0d tuples want %0d", rcv_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i])
                $display("FAIL rnd_tuple_%0d: got %h want %h", i, rcv_q[i], exp_q[i]); else passed++;
        end
        checks++; if (pkt_count !== CNT_W'(exp_pkt)) $display("FAIL rnd_pkt_count: got %0d want %0d", pkt_count, exp_pkt); else passed++;
        checks++; if (drop_count !== CNT_W'(exp_drop)) $display("FAIL rnd_drop_count: got %0d want %0d", drop_count, exp_drop); else passed++;
    endtask

    initial begin
        test_reset();
        test_tcp();
        test_icmp();
        test_bad_version();
        test_truncated();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
